// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode values and datapath select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BR_IMM = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // States that wait on mem_ready and therefore run the wait timer.
    function automatic logic is_wait_state(state_e s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller bundle: instruction/memory status in, datapath enables and
// debug/error status out. The controller takes the slave side.
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        output opcode, mem_ready,
        input  iord, mem_read, mem_write, ir_write, pc_write, branch,
        input  reg_dst, mem_to_reg, reg_write, alu_src_a,
        input  alu_src_b, pc_src, alu_op, state, illegal_op, mem_timeout
    );

    modport slave (
        input  opcode, mem_ready,
        output iord, mem_read, mem_write, ir_write, pc_write, branch,
        output reg_dst, mem_to_reg, reg_write, alu_src_a,
        output alu_src_b, pc_src, alu_op, state, illegal_op, mem_timeout
    );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Eight-bit memory wait counter; flags when the count reaches LIMIT so the
// controller can abandon a stalled access.
module mem_wait_timer #(
    parameter logic [7:0] LIMIT = 8'd15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic limit_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_o = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: a state register plus a combinational decoder
// driving datapath enables, with a watchdog on every memory wait.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    state_e state_q;
    state_e state_d;

    logic in_wait;
    logic limit_hit;
    logic timed_out;
    logic timer_en;
    logic timer_clr;

    // The timer only keeps counting while we are stuck waiting; any other
    // cycle (including the one that leaves a wait state) zeroes it, so every
    // entry into a wait state starts from 0.
    assign in_wait   = is_wait_state(state_q);
    assign timed_out = in_wait && !bus.mem_ready && limit_hit;
    assign timer_en  = in_wait && !bus.mem_ready && !limit_hit;
    assign timer_clr = !timer_en;

    mem_wait_timer #(
        .LIMIT (8'(TIMEOUT_CYCLES - 1))
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .limit_o  (limit_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.branch      = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_REG;
        bus.pc_src      = PC_SRC_ALU;
        bus.alu_op      = ALU_OP_ADD;
        bus.illegal_op  = 1'b0;
        bus.mem_timeout = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = DECODE;
                end else if (timed_out) begin
                    // Reissue the fetch; PC was never advanced.
                    bus.mem_timeout = 1'b1;
                    state_d         = FETCH;
                end
            end
            DECODE: begin
                bus.alu_src_b = SRCB_BR_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEMWB;
                end else if (timed_out) begin
                    bus.mem_timeout = 1'b1;
                    state_d         = FETCH;
                end
            end
            MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                state_d        = FETCH;
            end
            MEMWRITE: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timed_out) begin
                    bus.mem_timeout = 1'b1;
                    state_d         = FETCH;
                end
            end
            EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_FUNCT;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALU_OP_SUB;
                bus.branch    = 1'b1;
                bus.pc_src    = PC_SRC_ALUOUT;
                state_d       = FETCH;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = ADDIWB;
            end
            ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_src   = PC_SRC_JUMP;
                bus.pc_write = 1'b1;
                state_d      = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: an instruction-level model queues the expected control
// word for every cycle; an independent monitor pops and compares each cycle.
module tb_multicycle_ctrl;

    localparam int T = 4;

    localparam int ST_FETCH    = 0;
    localparam int ST_DECODE   = 1;
    localparam int ST_MEMADR   = 2;
    localparam int ST_MEMREAD  = 3;
    localparam int ST_MEMWB    = 4;
    localparam int ST_MEMWRITE = 5;
    localparam int ST_EXECUTE  = 6;
    localparam int ST_ALUWB    = 7;
    localparam int ST_BRANCH   = 8;
    localparam int ST_ADDIEX   = 9;
    localparam int ST_ADDIWB   = 10;
    localparam int ST_JUMP     = 11;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    typedef struct packed {
        logic [3:0] state;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       mem_timeout;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   stepIdx;
    int   resetAt;
    bit   aborted;

    function automatic bit isLegal(logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RTY) || (op == BEQ) ||
               (op == ADDI) || (op == JMP);
    endfunction

    // Control word each state presents, straight from the state table.
    function automatic obs_t ctrl(int st, bit rdy, bit tmo, bit ill);
        obs_t e;
        e       = '0;
        e.state = 4'(st);
        case (st)
            ST_FETCH: begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = rdy;  e.pc_write  = rdy;
            end
            ST_DECODE:   e.alu_src_b = 2'b11;
            ST_MEMADR:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_MEMREAD:  begin e.iord = 1'b1; e.mem_read = 1'b1; end
            ST_MEMWB:    begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            ST_MEMWRITE: begin e.iord = 1'b1; e.mem_write = 1'b1; end
            ST_EXECUTE:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            ST_ALUWB:    begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            ST_BRANCH: begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01;
                e.branch    = 1'b1; e.pc_src = 2'b01;
            end
            ST_ADDIEX:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            ST_ADDIWB:   e.reg_write = 1'b1;
            ST_JUMP:     begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
            default: ;
        endcase
        e.illegal_op  = ill;
        e.mem_timeout = tmo;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.state       = bus.state;
        a.iord        = bus.iord;
        a.mem_read    = bus.mem_read;
        a.mem_write   = bus.mem_write;
        a.ir_write    = bus.ir_write;
        a.pc_write    = bus.pc_write;
        a.branch      = bus.branch;
        a.reg_dst     = bus.reg_dst;
        a.mem_to_reg  = bus.mem_to_reg;
        a.reg_write   = bus.reg_write;
        a.alu_src_a   = bus.alu_src_a;
        a.alu_src_b   = bus.alu_src_b;
        a.pc_src      = bus.pc_src;
        a.alu_op      = bus.alu_op;
        a.illegal_op  = bus.illegal_op;
        a.mem_timeout = bus.mem_timeout;
        return a;
    endfunction

    // One clock of stimulus; reset is injected on the chosen step.
    task automatic applyStimulus(int st, bit rdy, bit tmo, bit ill);
        reset         = (stepIdx == resetAt);
        bus.mem_ready = rdy;
        expQ.push_back(ctrl(st, rdy, tmo, ill));
        if (reset) aborted = 1'b1;
        stepIdx++;
        @(posedge clk);
        #1;
    endtask

    task automatic plainStep(int st);
        applyStimulus(st, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    // A memory wait of 'waits' low-ready cycles; gives up at the T-th low cycle.
    task automatic waitPhase(int st, int waits, output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        forever begin
            if (aborted) return;
            if (k < waits) begin
                if (k == T - 1) begin
                    applyStimulus(st, 1'b0, 1'b1, 1'b0);
                    return;
                end
                applyStimulus(st, 1'b0, 1'b0, 1'b0);
            end else begin
                applyStimulus(st, 1'b1, 1'b0, 1'b0);
                ok = 1'b1;
                return;
            end
            k++;
        end
    endtask

    task automatic runInstr(logic [5:0] op, int fw, int mw, int rAt);
        bit ok;
        bit legal;
        stepIdx    = 0;
        resetAt    = rAt;
        aborted    = 1'b0;
        bus.opcode = op;
        ok         = 1'b0;
        while (!ok) begin
            waitPhase(ST_FETCH, fw, ok);
            if (aborted) return;
            if (!ok) fw -= T;
        end
        legal = isLegal(op);
        applyStimulus(ST_DECODE, 1'($urandom_range(0, 1)), 1'b0, !legal);
        if (aborted || !legal) return;
        case (op)
            LW: begin
                plainStep(ST_MEMADR);
                if (aborted) return;
                waitPhase(ST_MEMREAD, mw, ok);
                if (aborted || !ok) return;
                plainStep(ST_MEMWB);
            end
            SW: begin
                plainStep(ST_MEMADR);
                if (aborted) return;
                waitPhase(ST_MEMWRITE, mw, ok);
            end
            RTY: begin
                plainStep(ST_EXECUTE);
                if (aborted) return;
                plainStep(ST_ALUWB);
            end
            ADDI: begin
                plainStep(ST_ADDIEX);
                if (aborted) return;
                plainStep(ST_ADDIWB);
            end
            BEQ: plainStep(ST_BRANCH);
            default: plainStep(ST_JUMP);
        endcase
    endtask

    task automatic checkOutput(obs_t e);
        obs_t a;
        a = sample();
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("[TB] FAIL cycle_word at %0t: actual state=%0d word=%h, required state=%0d word=%h",
                     $time, a.state, a, e.state, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        logic [5:0] legalOps [6];
        logic [5:0] op;
        int fw;
        int mw;
        int rAt;
        legalOps = '{LW, SW, RTY, BEQ, ADDI, JMP};

        reset         = 1'b1;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        runInstr(LW,     0, 0, -1);
        runInstr(SW,     0, 3, -1);
        runInstr(RTY,    0, 0, -1);
        runInstr(BEQ,    0, 0, -1);
        runInstr(JMP,    0, 0, -1);
        runInstr(6'h3f,  0, 0, -1);
        runInstr(LW,     0, 4, -1);
        runInstr(LW,     0, 3, -1);
        runInstr(ADDI,   5, 0, -1);
        runInstr(LW,     0, 2,  4);
        runInstr(RTY,    0, 0,  2);
        runInstr(SW,     3, 5, -1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                op = legalOps[$urandom_range(0, 5)];
            end else begin
                do op = 6'($urandom); while (isLegal(op));
            end
            fw  = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 2 * T + 1);
            mw  = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(0, 2 * T + 1);
            rAt = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
            runInstr(op, fw, mw, rAt);
        end

        @(negedge clk);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drain: actual %0d pending, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
